cacheline_adapter: RTL and testbench



---
 rtl/cacheline_adapter.sv | 174 +++++++++++++++++
 tb/tb_cacheline_adapter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_adapter
//  Purpose  : Responder for the data cache's 256-bit line port. A line fill
//             collects four 64-bit burst beats into one line; a writeback
//             splits the latched line into four beats. Beat 0 is bits [63:0].
//  Revision : 1.0  initial release
//
//  Ports
//    clk, rst          clock; synchronous active-low reset (0 = reset)
//    pmem_read/write   cache requests, held until pmem_resp
//    pmem_address      line address from cache
//    pmem_wdata        writeback line
//    pmem_rdata        filled line (holds until the next fill completes)
//    pmem_resp         one-cycle completion pulse
//    mem_read/write    burst requests toward memory
//    mem_address       line-aligned burst address, held for the burst
//    burst_i/burst_o   read / write beat data
//    mem_resp          per-beat acknowledge
//    rd_count/wr_count completed fill / writeback counters (saturating),
//                      present only when CACHELINE_ADAPTER_PERF_EN is defined
//
//  Every output is a register; nothing combinational reaches an output.
// ============================================================================
module cacheline_adapter #(
    parameter int s_offset = 5,
    parameter int s_beat   = 64,
    parameter int n_beats  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pmem_read,
    input  logic                         pmem_write,
    input  logic [31:0]                  pmem_address,
    input  logic [8*(2**s_offset)-1:0]   pmem_wdata,
    output logic [8*(2**s_offset)-1:0]   pmem_rdata,
    output logic                         pmem_resp,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [31:0]                  mem_address,
    input  logic [s_beat-1:0]            burst_i,
    output logic [s_beat-1:0]            burst_o,
`ifdef CACHELINE_ADAPTER_PERF_EN
    output logic [31:0]                  rd_count,
    output logic [31:0]                  wr_count,
`endif
    input  logic                         mem_resp
);

    localparam int LINE_W = 8 * (2**s_offset);
    localparam int CNT_W  = $clog2(n_beats);

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(n_beats - 1);
    localparam logic [31:0]      c_addr_mask = 32'((64'd1 << s_offset) - 64'd1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [LINE_W-1:0]   r_line;    // fill assembly buffer
    logic [LINE_W-1:0]   r_wdata;   // writeback line latched at accept

    logic [CNT_W-1:0]    w_cnt_inc;
    logic [31:0]         w_aligned;
    logic [LINE_W-1:0]   w_line_next;
    logic                w_rd_last;
    logic                w_wr_last;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_aligned = pmem_address & ~c_addr_mask;
    assign w_rd_last = (r_state == RD_BURST) && mem_resp && (r_cnt == c_last_beat);
    assign w_wr_last = (r_state == WR_BURST) && mem_resp && (r_cnt == c_last_beat);

    // Line buffer with the current beat merged in; on the final beat this is
    // the complete line, so it can be loaded straight into pmem_rdata.
    always_comb begin
        w_line_next = r_line;
        w_line_next[int'(r_cnt)*s_beat +: s_beat] = burst_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_line      <= '0;
            r_wdata     <= '0;
            pmem_rdata  <= '0;
            pmem_resp   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            burst_o     <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Writeback wins so a dirty victim leaves before its refill.
                    if (pmem_write) begin
                        r_state     <= WR_BURST;
                        r_cnt       <= '0;
                        r_wdata     <= pmem_wdata;
                        burst_o     <= pmem_wdata[s_beat-1:0];
                        mem_address <= w_aligned;
                        mem_write   <= 1'b1;
                    end else if (pmem_read) begin
                        r_state     <= RD_BURST;
                        r_cnt       <= '0;
                        mem_address <= w_aligned;
                        mem_read    <= 1'b1;
                    end
                end
                RD_BURST: begin
                    if (mem_resp) begin
                        r_line <= w_line_next;
                        r_cnt  <= w_cnt_inc;
                        if (w_rd_last) begin
                            r_state    <= RD_DONE;
                            mem_read   <= 1'b0;
                            pmem_resp  <= 1'b1;
                            pmem_rdata <= w_line_next;
                        end
                    end
                end
                RD_DONE: begin
                    r_state <= IDLE;
                end
                WR_BURST: begin
                    if (mem_resp) begin
                        r_cnt <= w_cnt_inc;
                        // Present the next beat as soon as the current one is taken.
                        burst_o <= r_wdata[int'(w_cnt_inc)*s_beat +: s_beat];
                        if (w_wr_last) begin
                            r_state   <= WR_DONE;
                            mem_write <= 1'b0;
                            pmem_resp <= 1'b1;
                        end
                    end
                end
                WR_DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef CACHELINE_ADAPTER_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (w_rd_last && (rd_count != 32'hFFFF_FFFF)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (w_wr_last && (wr_count != 32'hFFFF_FFFF)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cacheline_adapter
//  Purpose  : Self-checking bench for cacheline_adapter. A vector table covers
//             a basic fill followed by a writeback with a stall; hand-written
//             sequences cover a heavily stalled fill, simultaneous requests,
//             reset mid-burst and (when CACHELINE_ADAPTER_PERF_EN is defined)
//             the completion counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp, mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  burst_i, burst_o;
    logic         mem_resp;
`ifdef CACHELINE_ADAPTER_PERF_EN
    logic [31:0]  rd_count, wr_count;
`endif

    cacheline_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .burst_i      (burst_i),
        .burst_o      (burst_o),
`ifdef CACHELINE_ADAPTER_PERF_EN
        .rd_count     (rd_count),
        .wr_count     (wr_count),
`endif
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [63:0]  bi;
        logic         mresp;
        logic         e_mrd;
        logic         e_mwr;
        logic         e_resp;
        logic [31:0]  e_maddr;
        logic         chk_bo;
        logic [63:0]  e_bo;
        logic         chk_rd;
        logic [255:0] e_rd;
    } vec_t;

    localparam logic [63:0] A0 = 64'hA0A0_A0A0_A0A0_A0A0, A1 = 64'hA1A1_A1A1_A1A1_A1A1;
    localparam logic [63:0] A2 = 64'hA2A2_A2A2_A2A2_A2A2, A3 = 64'hA3A3_A3A3_A3A3_A3A3;
    localparam logic [63:0] D0 = 64'hD0D0_D0D0_D0D0_D0D0, D1 = 64'hD1D1_D1D1_D1D1_D1D1;
    localparam logic [63:0] D2 = 64'hD2D2_D2D2_D2D2_D2D2, D3 = 64'hD3D3_D3D3_D3D3_D3D3;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [63:0] bi, input logic mresp,
                                input logic e_mrd, input logic e_mwr, input logic e_resp,
                                input logic [31:0] e_maddr, input logic chk_bo,
                                input logic [63:0] e_bo, input logic chk_rd,
                                input logic [255:0] e_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.bi = bi; v.mresp = mresp;
        v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_resp = e_resp; v.e_maddr = e_maddr;
        v.chk_bo = chk_bo; v.e_bo = e_bo; v.chk_rd = chk_rd; v.e_rd = e_rd;
        return v;
    endfunction

    // Runs a four-beat fill that is acked every cycle; request already accepted.
    task automatic fill(input logic [63:0] b0, input logic [63:0] b1,
                        input logic [63:0] b2, input logic [63:0] b3, input string tag);
        logic [63:0] bv [4];
        bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
        for (int i = 0; i < 4; i++) begin
            mem_resp = 1'b1;
            burst_i  = bv[i];
            tick();
        end
        chk({tag, "_resp"}, 256'(pmem_resp), 256'(1));
        chk({tag, "_rdata"}, pmem_rdata, {b3, b2, b1, b0});
        pmem_read = 1'b0;
        mem_resp  = 1'b0;
        tick();
    endtask

    vec_t        tbl [13];
    logic [255:0] line_a;
    logic [63:0]  bvals [4];
    int           pat [7];
    int           acks;

    initial begin
        rst = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
        pmem_wdata = '0; burst_i = '0; mem_resp = 1'b0;
        line_a = {A3, A2, A1, A0};

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_mem_read",  256'(mem_read),    256'(0));
        chk("rst_mem_write", 256'(mem_write),   256'(0));
        chk("rst_pmem_resp", 256'(pmem_resp),   256'(0));
        chk("rst_rdata",     pmem_rdata,        256'(0));
        chk("rst_burst_o",   256'(burst_o),     256'(0));
        chk("rst_maddr",     256'(mem_address), 256'(0));
        rst = 1'b1;
        tick();

        // ---------------- vector table: fill, then writeback with a stall ----
        pmem_wdata = {D3, D2, D1, D0};
        //             rd wr addr          bi   mr  mrd mwr rsp maddr         cbo bo  crd rdata
        tbl[0]  = mk(1, 0, 32'h1234_567C, '0, 0,  1, 0, 0, 32'h1234_5660, 0, '0, 1, '0);
        tbl[1]  = mk(1, 0, 32'h1234_567C, A0, 1,  1, 0, 0, 32'h1234_5660, 0, '0, 0, '0);
        tbl[2]  = mk(1, 0, 32'h1234_567C, A1, 1,  1, 0, 0, 32'h1234_5660, 0, '0, 0, '0);
        tbl[3]  = mk(1, 0, 32'h1234_567C, A2, 1,  1, 0, 0, 32'h1234_5660, 0, '0, 0, '0);
        tbl[4]  = mk(1, 0, 32'h1234_567C, A3, 1,  0, 0, 1, 32'h1234_5660, 0, '0, 1, line_a);
        tbl[5]  = mk(0, 0, 32'h1234_567C, '0, 0,  0, 0, 0, 32'h1234_5660, 0, '0, 1, line_a);
        tbl[6]  = mk(0, 1, 32'hCAFE_BABF, '0, 0,  0, 1, 0, 32'hCAFE_BAA0, 1, D0, 1, line_a);
        tbl[7]  = mk(0, 1, 32'hCAFE_BABF, '0, 1,  0, 1, 0, 32'hCAFE_BAA0, 1, D1, 0, '0);
        tbl[8]  = mk(0, 1, 32'hFFFF_FFFF, '0, 0,  0, 1, 0, 32'hCAFE_BAA0, 1, D1, 0, '0);
        tbl[9]  = mk(0, 1, 32'hCAFE_BABF, '0, 1,  0, 1, 0, 32'hCAFE_BAA0, 1, D2, 0, '0);
        tbl[10] = mk(0, 1, 32'hCAFE_BABF, '0, 1,  0, 1, 0, 32'hCAFE_BAA0, 1, D3, 0, '0);
        tbl[11] = mk(0, 1, 32'hCAFE_BABF, '0, 1,  0, 0, 1, 32'hCAFE_BAA0, 0, '0, 1, line_a);
        tbl[12] = mk(0, 0, 32'hCAFE_BABF, '0, 1,  0, 0, 0, 32'hCAFE_BAA0, 0, '0, 1, line_a);

        for (int i = 0; i < 13; i++) begin
            pmem_read    = tbl[i].rd;
            pmem_write   = tbl[i].wr;
            pmem_address = tbl[i].addr;
            burst_i      = tbl[i].bi;
            mem_resp     = tbl[i].mresp;
            tick();
            chk($sformatf("v%0d_mem_read", i),  256'(mem_read),    256'(tbl[i].e_mrd));
            chk($sformatf("v%0d_mem_write", i), 256'(mem_write),   256'(tbl[i].e_mwr));
            chk($sformatf("v%0d_pmem_resp", i), 256'(pmem_resp),   256'(tbl[i].e_resp));
            chk($sformatf("v%0d_maddr", i),     256'(mem_address), 256'(tbl[i].e_maddr));
            if (tbl[i].chk_bo) chk($sformatf("v%0d_burst_o", i), 256'(burst_o), 256'(tbl[i].e_bo));
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata", i), pmem_rdata, tbl[i].e_rd);
        end
        mem_resp = 1'b0;
        pmem_wdata = '0;

        // ---------------- stalled fill: ack pattern 1,0,0,1,1,0,1 ----------
        bvals[0] = 64'hB0B0_0000_0000_00B0; bvals[1] = 64'hB1B1_1111_1111_11B1;
        bvals[2] = 64'hB2B2_2222_2222_22B2; bvals[3] = 64'hB3B3_3333_3333_33B3;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        pmem_read = 1'b1; pmem_address = 32'h0000_1008;
        tick();
        chk("stall_accept_mem_read", 256'(mem_read), 256'(1));
        chk("stall_maddr", 256'(mem_address), 256'(32'h0000_1000));
        acks = 0;
        for (int i = 0; i < 7; i++) begin
            mem_resp = (pat[i] != 0);
            burst_i  = (pat[i] != 0) ? bvals[acks] : JUNK;
            tick();
            if (pat[i] != 0) acks++;
            if (acks < 4) begin
                chk($sformatf("stall%0d_mem_read", i), 256'(mem_read), 256'(1));
                chk($sformatf("stall%0d_resp", i), 256'(pmem_resp), 256'(0));
            end else begin
                chk("stall_done_resp", 256'(pmem_resp), 256'(1));
                chk("stall_done_mem_read", 256'(mem_read), 256'(0));
                chk("stall_done_rdata", pmem_rdata, {bvals[3], bvals[2], bvals[1], bvals[0]});
            end
        end
        pmem_read = 1'b0; mem_resp = 1'b0;
        tick();
        chk("stall_resp_single_pulse", 256'(pmem_resp), 256'(0));

        // ---------------- read and write together: write goes first ---------
        pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_2040;
        pmem_wdata = {4{64'h5555_AAAA_5555_AAAA}};
        tick();
        chk("both_mem_write", 256'(mem_write), 256'(1));
        chk("both_mem_read",  256'(mem_read),  256'(0));
        for (int i = 0; i < 4; i++) begin
            mem_resp = 1'b1;
            tick();
        end
        chk("both_wr_resp", 256'(pmem_resp), 256'(1));
        chk("both_wr_done_mem_write", 256'(mem_write), 256'(0));
        pmem_write = 1'b0; mem_resp = 1'b0;
        tick();
        chk("both_idle_gap_mem_read", 256'(mem_read), 256'(0));
        chk("both_idle_gap_resp", 256'(pmem_resp), 256'(0));
        tick();
        chk("both_read_accepted", 256'(mem_read), 256'(1));
        fill(64'hC0, 64'hC1, 64'hC2, 64'hC3, "both_read");

        // ---------------- reset during beat 2 of a fill ---------------------
        pmem_read = 1'b1; pmem_address = 32'h0000_3000;
        tick();
        mem_resp = 1'b1; burst_i = 64'hE0; tick();
        burst_i = 64'hE1; tick();
        rst = 1'b0; burst_i = 64'hE2; tick();
        chk("mid_rst_mem_read", 256'(mem_read),  256'(0));
        chk("mid_rst_resp",     256'(pmem_resp), 256'(0));
        chk("mid_rst_rdata",    pmem_rdata,      256'(0));
        rst = 1'b1; pmem_read = 1'b0; mem_resp = 1'b1; burst_i = 64'hE3;
        tick();
        chk("post_rst_no_resp", 256'(pmem_resp), 256'(0));
        chk("post_rst_idle", 256'(mem_read), 256'(0));
        mem_resp = 1'b0;
        pmem_read = 1'b1; pmem_address = 32'h0000_4010;
        tick();
        chk("post_rst_accept", 256'(mem_read), 256'(1));
        fill(64'hF0, 64'hF1, 64'hF2, 64'hF3, "post_rst_read");

`ifdef CACHELINE_ADAPTER_PERF_EN
        // Completed since the mid-burst reset: one fill; that reset cleared the rest.
        chk("perf_rd_count", 256'(rd_count), 256'(1));
        chk("perf_wr_count", 256'(wr_count), 256'(0));
        // Two more fills and two writebacks.
        for (int n = 0; n < 2; n++) begin
            pmem_read = 1'b1; tick();
            fill(64'h1, 64'h2, 64'h3, 64'h4, "perf_read");
            pmem_write = 1'b1; tick();
            for (int i = 0; i < 4; i++) begin mem_resp = 1'b1; tick(); end
            pmem_write = 1'b0; mem_resp = 1'b0; tick();
        end
        chk("perf_rd_count3", 256'(rd_count), 256'(3));
        chk("perf_wr_count2", 256'(wr_count), 256'(2));
        rst = 1'b0; tick();
        chk("perf_rd_clear", 256'(rd_count), 256'(0));
        chk("perf_wr_clear", 256'(wr_count), 256'(0));
        rst = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
